// File: rtl/control_decode_queue_if.sv
// control_decode_queue_if: instruction-in / control-word-out bundle for
// control_decode_queue. The master side is whoever produces instruction fields
// and consumes decoded control words; the slave side is the queue itself.
interface control_decode_queue_if #(
  parameter int EXE_CMD_W = 4,
  parameter int DEPTH     = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           mode;
  logic [3:0]           opcode;
  logic                 s_bit;
  logic [3:0]           cond;
  logic [3:0]           flags;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [EXE_CMD_W-1:0] exe_cmd;
  logic                 s_update;
  logic                 branch;
  logic                 mem_wr_en;
  logic                 mem_rd_en;
  logic                 wb_en;
  logic                 undef;
  logic [CNT_W-1:0]     count;

  modport master (
    output in_valid, mode, opcode, s_bit, cond, flags, flush, out_ready,
    input  in_ready, out_valid, exe_cmd, s_update, branch, mem_wr_en,
           mem_rd_en, wb_en, undef, count
  );

  modport slave (
    input  in_valid, mode, opcode, s_bit, cond, flags, flush, out_ready,
    output in_ready, out_valid, exe_cmd, s_update, branch, mem_wr_en,
           mem_rd_en, wb_en, undef, count
  );
endinterface

// File: rtl/control_decode_queue.sv
// control_decode_queue: decodes ARM-style instruction fields (mode, opcode,
// S bit) into an execute control word at accept time and buffers the words in
// a DEPTH-entry FIFO. The head word drives the control outputs; an empty queue
// presents all-zero controls.
// Optional feature macro: CTRL_COND_EVAL_EN -- when defined, the condition
// field is checked against the sampled flags and a failing word is enqueued
// with all of its enables cleared (exe_cmd and undef kept).
module control_decode_queue #(
  parameter int EXE_CMD_W = 4,
  parameter int DEPTH     = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  control_decode_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

`ifdef CTRL_COND_EVAL_EN
  localparam bit COND_EVAL_EN = 1'b1;
`else
  localparam bit COND_EVAL_EN = 1'b0;
`endif

  typedef struct packed {
    logic       undef;
    logic       wb_en;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic       branch;
    logic       s_update;
    logic [3:0] cmd;
  } ctrl_word_t;

  // Instruction class / opcode to control word; anything not listed is undef
  function automatic ctrl_word_t decode_word(input logic [1:0] m,
                                             input logic [3:0] op,
                                             input logic       s);
    ctrl_word_t w;
    w = '0;
    case (m)
      2'b00: begin
        w.wb_en    = 1'b1;
        w.s_update = s;
        case (op)
          4'b1101: w.cmd = 4'd1;  // MOV
          4'b1111: w.cmd = 4'd9;  // MVN
          4'b0100: w.cmd = 4'd2;  // ADD
          4'b0101: w.cmd = 4'd3;  // ADC
          4'b0010: w.cmd = 4'd4;  // SUB
          4'b0110: w.cmd = 4'd5;  // SBC
          4'b0000: w.cmd = 4'd6;  // AND
          4'b1100: w.cmd = 4'd7;  // ORR
          4'b0001: w.cmd = 4'd8;  // EOR
          4'b1010: begin          // CMP: flags only, no writeback
            w.cmd      = 4'd4;
            w.s_update = 1'b1;
            w.wb_en    = 1'b0;
          end
          4'b1000: begin          // TST: flags only, no writeback
            w.cmd      = 4'd6;
            w.s_update = 1'b1;
            w.wb_en    = 1'b0;
          end
          default: begin
            w       = '0;
            w.undef = 1'b1;
          end
        endcase
      end
      2'b01: begin
        w.cmd = 4'd2;
        if (s) begin
          w.mem_rd_en = 1'b1;
          w.wb_en     = 1'b1;
        end else begin
          w.mem_wr_en = 1'b1;
        end
      end
      2'b10: begin
        w.cmd    = 4'd0;
        w.branch = 1'b1;
      end
      default: begin
        w.undef = 1'b1;
      end
    endcase
    return w;
  endfunction

  // ARM condition field against {N,Z,C,V}; 1110 and 1111 both always pass
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cy;
      4'b0011: r = !cy;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cy && !z;
      4'b1001: r = !cy || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  ctrl_word_t       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             ready_en_r;

  logic       in_ready_s;
  logic       out_valid_s;
  logic       push_s;
  logic       pop_s;
  logic       exec_s;
  ctrl_word_t decoded_s;
  ctrl_word_t word_s;
  ctrl_word_t head_s;

  // Handshake qualifiers; ready stays low until the first edge after reset
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (ready_en_r && (count_r < DEPTH_C)) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    out_valid_s = (count_r != {CNT_W{1'b0}});
    push_s      = bus.in_valid && in_ready_s;
    pop_s       = out_valid_s && bus.out_ready;
  end

  // Decode incoming fields; a failed condition clears every enable
  always_comb begin
    decoded_s = decode_word(bus.mode, bus.opcode, bus.s_bit);
    exec_s    = !COND_EVAL_EN || cond_pass(bus.cond, bus.flags);
    word_s    = decoded_s;
    if (exec_s) begin
      word_s = decoded_s;
    end else begin
      word_s.s_update  = 1'b0;
      word_s.branch    = 1'b0;
      word_s.mem_wr_en = 1'b0;
      word_s.mem_rd_en = 1'b0;
      word_s.wb_en     = 1'b0;
    end
  end

  // Queue storage, pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      ready_en_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      ready_en_r <= 1'b1;
      if (bus.flush) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= word_s;
          wr_ptr_r        <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Head word, forced to zero whenever the queue is empty
  always_comb begin
    head_s = '0;
    if (out_valid_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.exe_cmd   = EXE_CMD_W'(head_s.cmd);
  assign bus.s_update  = head_s.s_update;
  assign bus.branch    = head_s.branch;
  assign bus.mem_wr_en = head_s.mem_wr_en;
  assign bus.mem_rd_en = head_s.mem_rd_en;
  assign bus.wb_en     = head_s.wb_en;
  assign bus.undef     = head_s.undef;
  assign bus.count     = count_r;
endmodule
